// File: rtl/shunt_fringe.sv
// Fringe bridge: frames local puts/EOS onto a TX word stream and
// parses RX frames into a per-signal receive database.
module shunt_fringe #(
    parameter int          N_SIG  = 4,
    parameter int          DW     = 64,
    parameter logic [7:0]  MY_ID  = 8'h01,
    parameter logic [31:0] SIM_ID = 32'h0,
    localparam int         SW     = (N_SIG > 1) ? $clog2(N_SIG) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             put_req_i,
    input  logic [7:0]       put_dst_i,
    input  logic [SW-1:0]    put_sig_i,
    input  logic             put_logic_i,
    input  logic [DW-1:0]    put_data_i,
    input  logic [DW-1:0]    put_mask_i,
    output logic             put_status_o,
    input  logic             get_req_i,
    input  logic [7:0]       get_src_i,
    input  logic [SW-1:0]    get_sig_i,
    output logic             get_success_o,
    output logic [DW-1:0]    get_data_o,
    output logic [DW-1:0]    get_mask_o,
    output logic [N_SIG-1:0] sig_valid_o,
    input  logic             eos_req_i,
    output logic             eos_done_o,
    output logic [31:0]      time_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic [DW-1:0]    tx_data_o,
    input  logic             rx_valid_i,
    output logic             rx_ready_o,
    input  logic [DW-1:0]    rx_data_i,
    output logic [7:0]       err_cnt_o
);

    localparam logic [7:0] TY_BIT = 8'h01;
    localparam logic [7:0] TY_LOG = 8'h02;
    localparam logic [7:0] TY_EOS = 8'hFF;

    typedef enum logic [2:0] {
        TX_IDLE, TX_HDR, TX_PAY0, TX_PAY1, TX_EOS
    } tx_st_t;

    typedef enum logic [1:0] {
        R_HDR, R_PAY0, R_PAY1, R_DROP
    } rx_st_t;

    function automatic logic [DW-1:0] mk_hdr(
        input logic [7:0] typ,
        input logic [7:0] dst,
        input logic [7:0] sig
    );
        logic [DW-1:0] h;
        h           = '0;
        h[DW-1 -: 8]  = typ;
        h[DW-9 -: 8]  = MY_ID;
        h[DW-17 -: 8] = dst;
        h[DW-25 -: 8] = sig;
        h[31:0]       = SIM_ID;
        return h;
    endfunction

    // ---------------- timestamp ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) time_o <= '0;
        else         time_o <= time_o + 32'd1;
    end

    // ---------------- TX side ----------------
    tx_st_t          tx_st, tx_nx;
    logic [7:0]      p_dst;
    logic [SW-1:0]   p_sig;
    logic            p_logic;
    logic [DW-1:0]   p_data, p_mask;
    logic            put_acc, eos_sent, eos_pend;
    logic            rx_eos;

    always_comb begin
        tx_nx      = tx_st;
        tx_valid_o = 1'b0;
        tx_data_o  = '0;
        put_acc    = 1'b0;
        eos_sent   = 1'b0;
        unique case (tx_st)
            TX_IDLE: begin
                if (put_req_i && !eos_done_o) begin
                    put_acc = 1'b1;
                    tx_nx   = TX_HDR;
                end else if ((eos_req_i || eos_pend) && !eos_done_o) begin
                    tx_nx = TX_EOS;
                end
            end
            TX_HDR: begin
                tx_valid_o = 1'b1;
                tx_data_o  = mk_hdr(p_logic ? TY_LOG : TY_BIT, p_dst, 8'(p_sig));
                if (tx_ready_i) tx_nx = TX_PAY0;
            end
            TX_PAY0: begin
                tx_valid_o = 1'b1;
                tx_data_o  = p_data;
                if (tx_ready_i) tx_nx = p_logic ? TX_PAY1 : TX_IDLE;
            end
            TX_PAY1: begin
                tx_valid_o = 1'b1;
                tx_data_o  = p_mask;
                if (tx_ready_i) tx_nx = TX_IDLE;
            end
            TX_EOS: begin
                tx_valid_o = 1'b1;
                tx_data_o  = mk_hdr(TY_EOS, 8'h00, 8'h00);
                if (tx_ready_i) begin
                    tx_nx    = TX_IDLE;
                    eos_sent = 1'b1;
                end
            end
            default: tx_nx = TX_IDLE;
        endcase
    end

    assign put_status_o = (tx_st != TX_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_st   <= TX_IDLE;
            p_dst   <= '0;
            p_sig   <= '0;
            p_logic <= 1'b0;
            p_data  <= '0;
            p_mask  <= '0;
        end else begin
            tx_st <= tx_nx;
            if (put_acc) begin
                p_dst   <= put_dst_i;
                p_sig   <= put_sig_i;
                p_logic <= put_logic_i;
                p_data  <= put_data_i;
                p_mask  <= put_mask_i;
            end
        end
    end

    // An EOS request that loses to a put is remembered until TX idles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            eos_pend   <= 1'b0;
            eos_done_o <= 1'b0;
        end else begin
            if (tx_nx == TX_EOS || eos_done_o) eos_pend <= 1'b0;
            else if (eos_req_i)                eos_pend <= 1'b1;
            if (eos_sent || rx_eos) eos_done_o <= 1'b1;
        end
    end

    // ---------------- RX side ----------------
    rx_st_t          rx_st, rx_nx;
    logic [7:0]      h_typ, h_src, h_dst, h_sig;
    logic [31:0]     h_sim;
    logic            addr_ok, sig_ok, is_bit, is_log, is_eos;
    logic            rx_fire, hdr_ld, val_ld, wr_en, err_inc;
    logic [1:0]      n_pay, drop_q, drop_nx;
    logic [SW-1:0]   r_sig;
    logic [7:0]      r_src;
    logic            r_logic;
    logic [DW-1:0]   r_val, wr_data, wr_mask;

    assign rx_ready_o = rst_ni;
    assign rx_fire    = rx_valid_i & rx_ready_o;

    assign h_typ = rx_data_i[DW-1 -: 8];
    assign h_src = rx_data_i[DW-9 -: 8];
    assign h_dst = rx_data_i[DW-17 -: 8];
    assign h_sig = rx_data_i[DW-25 -: 8];
    assign h_sim = rx_data_i[31:0];

    assign is_bit  = (h_typ == TY_BIT);
    assign is_log  = (h_typ == TY_LOG);
    assign is_eos  = (h_typ == TY_EOS);
    assign addr_ok = (h_dst == MY_ID) && (h_sim == SIM_ID);
    assign sig_ok  = (32'(h_sig) < N_SIG);
    assign n_pay   = is_bit ? 2'd1 : (is_log ? 2'd2 : 2'd0);

    always_comb begin
        rx_nx   = rx_st;
        drop_nx = drop_q;
        hdr_ld  = 1'b0;
        val_ld  = 1'b0;
        wr_en   = 1'b0;
        err_inc = 1'b0;
        rx_eos  = 1'b0;
        unique case (rx_st)
            R_HDR: if (rx_fire) begin
                if (addr_ok && sig_ok && (is_bit || is_log)) begin
                    hdr_ld = 1'b1;
                    rx_nx  = R_PAY0;
                end else if (addr_ok && is_eos) begin
                    rx_eos = 1'b1;
                end else begin
                    err_inc = 1'b1;
                    if (n_pay != 2'd0) begin
                        drop_nx = n_pay;
                        rx_nx   = R_DROP;
                    end
                end
            end
            R_PAY0: if (rx_fire) begin
                if (r_logic) begin
                    val_ld = 1'b1;
                    rx_nx  = R_PAY1;
                end else begin
                    wr_en = 1'b1;
                    rx_nx = R_HDR;
                end
            end
            R_PAY1: if (rx_fire) begin
                wr_en = 1'b1;
                rx_nx = R_HDR;
            end
            R_DROP: if (rx_fire) begin
                drop_nx = drop_q - 2'd1;
                if (drop_q == 2'd1) rx_nx = R_HDR;
            end
            default: rx_nx = R_HDR;
        endcase
    end

    // LOGIC value word is staged so an entry is only ever updated whole
    assign wr_data = (rx_st == R_PAY1) ? r_val : rx_data_i;
    assign wr_mask = (rx_st == R_PAY1) ? rx_data_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_st     <= R_HDR;
            drop_q    <= '0;
            r_sig     <= '0;
            r_src     <= '0;
            r_logic   <= 1'b0;
            r_val     <= '0;
            err_cnt_o <= '0;
        end else begin
            rx_st  <= rx_nx;
            drop_q <= drop_nx;
            if (hdr_ld) begin
                r_sig   <= h_sig[SW-1:0];
                r_src   <= h_src;
                r_logic <= is_log;
            end
            if (val_ld) r_val <= rx_data_i;
            if (err_inc && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
        end
    end

    // ---------------- database and get ----------------
    logic [DW-1:0]    db_data [N_SIG];
    logic [DW-1:0]    db_mask [N_SIG];
    logic [7:0]       db_src  [N_SIG];
    logic [N_SIG-1:0] db_vld;
    logic             g_hit;

    assign g_hit       = get_req_i && db_vld[get_sig_i] && (db_src[get_sig_i] == get_src_i);
    assign sig_valid_o = db_vld;

    // RX write is last so its valid set wins over a same-entry get clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_vld <= '0;
            for (int i = 0; i < N_SIG; i++) begin
                db_data[i] <= '0;
                db_mask[i] <= '0;
                db_src[i]  <= '0;
            end
        end else begin
            if (g_hit) db_vld[get_sig_i] <= 1'b0;
            if (wr_en) begin
                db_data[r_sig] <= wr_data;
                db_mask[r_sig] <= wr_mask;
                db_src[r_sig]  <= r_src;
                db_vld[r_sig]  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            get_success_o <= 1'b0;
            get_data_o    <= '0;
            get_mask_o    <= '0;
        end else begin
            get_success_o <= g_hit;
            if (g_hit) begin
                get_data_o <= db_data[get_sig_i];
                get_mask_o <= db_mask[get_sig_i];
            end
        end
    end

endmodule

// File: tb/tb_shunt_fringe.sv
// Randomised bench for shunt_fringe against a frame-level reference model.
module tb_shunt_fringe;

    localparam int          N   = 4;
    localparam int          DW  = 64;
    localparam logic [7:0]  MY  = 8'h01;
    localparam logic [31:0] SIM = 32'h0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          put_req = 0, put_logic = 0, get_req = 0, eos_req = 0;
    logic [7:0]    put_dst = 0, get_src = 0;
    logic [1:0]    put_sig = 0, get_sig = 0;
    logic [63:0]   put_data = 0, put_mask = 0, rx_data = 0;
    logic          tx_ready = 0, rx_valid = 0;
    logic          put_status, get_success, eos_done, tx_valid, rx_ready;
    logic [63:0]   get_data, get_mask, tx_data;
    logic [N-1:0]  sig_valid;
    logic [31:0]   time_v;
    logic [7:0]    err_cnt;

    int n_chk = 0;
    int n_fail = 0;

    // reference model of the receive database
    logic [63:0] m_data [N];
    logic [63:0] m_mask [N];
    logic [7:0]  m_src  [N];
    logic [N-1:0] m_vld;
    int          m_err;

    shunt_fringe #(.N_SIG(N), .DW(DW), .MY_ID(MY), .SIM_ID(SIM)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .put_req_i(put_req), .put_dst_i(put_dst), .put_sig_i(put_sig),
        .put_logic_i(put_logic), .put_data_i(put_data), .put_mask_i(put_mask),
        .put_status_o(put_status),
        .get_req_i(get_req), .get_src_i(get_src), .get_sig_i(get_sig),
        .get_success_o(get_success), .get_data_o(get_data), .get_mask_o(get_mask),
        .sig_valid_o(sig_valid), .eos_req_i(eos_req), .eos_done_o(eos_done),
        .time_o(time_v),
        .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_data_o(tx_data),
        .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .rx_data_i(rx_data),
        .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] t, input logic [7:0] s,
                                        input logic [7:0] d, input logic [7:0] g,
                                        input logic [31:0] sim);
        return {t, s, d, g, sim};
    endfunction

    task automatic model_clear;
        for (int i = 0; i < N; i++) begin
            m_data[i] = '0;
            m_mask[i] = '0;
            m_src[i]  = '0;
        end
        m_vld = '0;
        m_err = 0;
    endtask

    // drives one RX frame (with random gaps) and updates the model
    task automatic send_frame(input logic [7:0] t, input logic [7:0] s,
                              input logic [7:0] d, input logic [7:0] g,
                              input logic [31:0] sim,
                              input logic [63:0] w0, input logic [63:0] w1);
        logic [63:0] words [$];
        int npay;
        npay = (t == 8'h01) ? 1 : ((t == 8'h02) ? 2 : 0);
        words.push_back(hdr(t, s, d, g, sim));
        if (npay >= 1) words.push_back(w0);
        if (npay == 2) words.push_back(w1);
        foreach (words[i]) begin
            if ($urandom_range(0, 3) == 0) tick();
            rx_valid = 1'b1;
            rx_data  = words[i];
            tick();
            rx_valid = 1'b0;
        end
        if (d == MY && sim == SIM && g < N && npay > 0) begin
            m_data[g] = w0;
            m_mask[g] = (t == 8'h02) ? w1 : 64'h0;
            m_src[g]  = s;
            m_vld[g]  = 1'b1;
        end else if (m_err < 255) begin
            m_err = m_err + 1;
        end
    endtask

    task automatic issue_get(input logic [7:0] s, input logic [1:0] g,
                             output logic exp_ok, output logic [63:0] exp_d,
                             output logic [63:0] exp_m);
        exp_ok = m_vld[g] && (m_src[g] == s);
        exp_d  = m_data[g];
        exp_m  = m_mask[g];
        if (exp_ok) m_vld[g] = 1'b0;
        get_req = 1'b1;
        get_src = s;
        get_sig = g;
        tick();
        get_req = 1'b0;
    endtask

    task automatic test_reset;
        tick();
        tick();
        n_chk++; if (time_v !== 32'd0) begin n_fail++; $display("FAIL reset_time: got %0d want 0", time_v); end
        n_chk++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
        n_chk++; if ({tx_valid, put_status, eos_done, get_success} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {tx_valid, put_status, eos_done, get_success});
        end
        n_chk++; if (sig_valid !== '0 || err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_db: got vld %b err %0d want 0 0", sig_valid, err_cnt);
        end
        rst_n = 1'b1;
        #1;
        n_chk++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ready_after: got %b want 1", rx_ready); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_chk++; if (time_v !== 32'(i)) begin n_fail++; $display("FAIL time_count: got %0d want %0d", time_v, i); end
        end
    endtask

    task automatic test_put_bit;
        logic [63:0] eh;
        eh = hdr(8'h01, MY, 8'h02, 8'h01, SIM);
        tx_ready = 1'b1;
        put_req = 1'b1; put_dst = 8'h02; put_sig = 2'd1; put_logic = 1'b0;
        put_data = 64'h1234; put_mask = 64'hFFFF;
        tick();
        put_data = 64'hDEAD; put_dst = 8'h09;
        n_chk++; if (tx_valid !== 1'b1 || tx_data !== eh || put_status !== 1'b1) begin
            n_fail++; $display("FAIL bit_hdr: got v%b %h s%b want v1 %h s1", tx_valid, tx_data, put_status, eh);
        end
        tick();
        put_req = 1'b0;
        n_chk++; if (tx_valid !== 1'b1 || tx_data !== 64'h1234 || put_status !== 1'b1) begin
            n_fail++; $display("FAIL bit_pay: got v%b %h s%b want v1 1234 s1", tx_valid, tx_data, put_status);
        end
        tick();
        n_chk++; if (put_status !== 1'b0 || tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL bit_done: got s%b v%b want s0 v0", put_status, tx_valid);
        end
    endtask

    task automatic test_put_logic_stall;
        logic [63:0] d, m, eh;
        logic [7:0]  dst;
        logic [1:0]  sg;
        d = {$urandom, $urandom}; m = {$urandom, $urandom};
        dst = 8'($urandom_range(2, 200)); sg = 2'($urandom);
        eh = hdr(8'h02, MY, dst, 8'(sg), SIM);
        tx_ready = 1'b0;
        put_req = 1'b1; put_dst = dst; put_sig = sg; put_logic = 1'b1;
        put_data = d; put_mask = m;
        tick();
        put_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (tx_valid !== 1'b1 || tx_data !== eh) begin
                n_fail++; $display("FAIL logic_stall%0d: got v%b %h want v1 %h", i, tx_valid, tx_data, eh);
            end
            if (i < 3) tick();
        end
        tx_ready = 1'b1;
        tick();
        n_chk++; if (tx_data !== d) begin n_fail++; $display("FAIL logic_val: got %h want %h", tx_data, d); end
        tick();
        n_chk++; if (tx_data !== m) begin n_fail++; $display("FAIL logic_mask: got %h want %h", tx_data, m); end
        tick();
        n_chk++; if (put_status !== 1'b0) begin n_fail++; $display("FAIL logic_done: got %b want 0", put_status); end
    endtask

    task automatic test_put_random;
        logic [63:0] exp_q [$];
        logic [63:0] e;
        int cyc;
        for (int k = 0; k < 8; k++) begin
            put_req = 1'b1; put_dst = 8'($urandom); put_sig = 2'($urandom);
            put_logic = 1'($urandom); put_data = {$urandom, $urandom};
            put_mask = {$urandom, $urandom};
            exp_q.push_back(hdr(put_logic ? 8'h02 : 8'h01, MY, put_dst, 8'(put_sig), SIM));
            exp_q.push_back(put_data);
            if (put_logic) exp_q.push_back(put_mask);
            tick();
            put_req = 1'b0;
            cyc = 0;
            while (put_status && cyc < 60) begin
                tx_ready = 1'($urandom);
                if (tx_valid && tx_ready) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
                    n_chk++; if (tx_data !== e) begin
                        n_fail++; $display("FAIL rand_tx%0d: got %h want %h", k, tx_data, e);
                    end
                end
                tick();
                cyc++;
            end
            n_chk++; if (cyc >= 60 || exp_q.size() != 0) begin
                n_fail++; $display("FAIL rand_tx_end%0d: cycles %0d left %0d want <60 and 0", k, cyc, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    task automatic test_rx_get;
        logic ok; logic [63:0] ed, em;
        send_frame(8'h01, 8'h02, MY, 8'h00, SIM, 64'hAB, 64'h0);
        n_chk++; if (sig_valid !== m_vld) begin n_fail++; $display("FAIL rx_valid: got %b want %b", sig_valid, m_vld); end
        issue_get(8'h02, 2'd0, ok, ed, em);
        n_chk++; if (get_success !== 1'b1 || get_data !== 64'hAB || ok !== 1'b1) begin
            n_fail++; $display("FAIL get_hit: got s%b %h want s1 ab", get_success, get_data);
        end
        n_chk++; if (sig_valid !== m_vld) begin n_fail++; $display("FAIL get_clear: got %b want %b", sig_valid, m_vld); end
        tick();
        n_chk++; if (get_success !== 1'b0) begin n_fail++; $display("FAIL get_pulse: got %b want 0", get_success); end
        issue_get(8'h02, 2'd0, ok, ed, em);
        n_chk++; if (get_success !== ok || get_data !== 64'hAB) begin
            n_fail++; $display("FAIL get_repeat: got s%b %h want s%b ab", get_success, get_data, ok);
        end
    endtask

    task automatic test_rx_bad_sim;
        logic ok; logic [63:0] ed, em, v, m;
        send_frame(8'h01, 8'h02, MY, 8'h02, SIM ^ 32'h5, 64'h77, 64'h0);
        n_chk++; if (err_cnt !== 8'(m_err) || sig_valid !== m_vld) begin
            n_fail++; $display("FAIL bad_sim: got err %0d vld %b want %0d %b", err_cnt, sig_valid, m_err, m_vld);
        end
        v = {$urandom, $urandom}; m = {$urandom, $urandom};
        send_frame(8'h02, 8'h03, MY, 8'h02, SIM, v, m);
        issue_get(8'h03, 2'd2, ok, ed, em);
        n_chk++; if (get_success !== ok || get_data !== ed || get_mask !== em) begin
            n_fail++; $display("FAIL after_bad: got s%b %h %h want s%b %h %h", get_success, get_data, get_mask, ok, ed, em);
        end
    endtask

    task automatic test_rx_random;
        logic ok; logic [63:0] ed, em;
        logic [7:0] t, s, d, g;
        logic [31:0] sim;
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 4))
                0, 1:    t = 8'h01;
                2, 3:    t = 8'h02;
                default: t = 8'h5A;
            endcase
            s = 8'($urandom_range(2, 4));
            d = ($urandom_range(0, 4) == 0) ? 8'h07 : MY;
            g = 8'($urandom_range(0, 5));
            sim = ($urandom_range(0, 7) == 0) ? 32'h1 : SIM;
            send_frame(t, s, d, g, sim, {$urandom, $urandom}, {$urandom, $urandom});
            n_chk++; if (sig_valid !== m_vld || err_cnt !== 8'(m_err)) begin
                n_fail++; $display("FAIL rx_rand%0d: got %b err %0d want %b err %0d", k, sig_valid, err_cnt, m_vld, m_err);
            end
            if ($urandom_range(0, 1) == 1) begin
                issue_get(8'($urandom_range(2, 4)), 2'($urandom), ok, ed, em);
                n_chk++; if (get_success !== ok || (ok && (get_data !== ed || get_mask !== em))) begin
                    n_fail++; $display("FAIL get_rand%0d: got s%b %h %h want s%b %h %h", k, get_success, get_data, get_mask, ok, ed, em);
                end
            end
        end
    endtask

    task automatic test_get_collision;
        logic ok; logic [63:0] ed, em, d1, d2;
        d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
        send_frame(8'h01, 8'h04, MY, 8'h01, SIM, d1, 64'h0);
        rx_valid = 1'b1;
        rx_data = hdr(8'h01, 8'h04, MY, 8'h01, SIM);
        tick();
        rx_data = d2;
        get_req = 1'b1; get_src = 8'h04; get_sig = 2'd1;
        tick();
        rx_valid = 1'b0; get_req = 1'b0;
        n_chk++; if (get_success !== 1'b1 || get_data !== d1 || sig_valid[1] !== 1'b1) begin
            n_fail++; $display("FAIL collide: got s%b %h v%b want s1 %h v1", get_success, get_data, sig_valid[1], d1);
        end
        m_data[1] = d2; m_vld[1] = 1'b1;
        issue_get(8'h04, 2'd1, ok, ed, em);
        n_chk++; if (get_success !== ok || get_data !== ed) begin
            n_fail++; $display("FAIL collide_new: got s%b %h want s%b %h", get_success, get_data, ok, ed);
        end
    endtask

    task automatic test_reset_midframe;
        rx_valid = 1'b1;
        rx_data = hdr(8'h02, 8'h02, MY, 8'h03, SIM);
        tick();
        rx_data = {$urandom, $urandom};
        tick();
        rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_chk++; if (sig_valid !== '0 || err_cnt !== 8'd0 || time_v !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset: got %b %0d %0d want 0 0 0", sig_valid, err_cnt, time_v);
        end
        tick();
        rst_n = 1'b1;
        model_clear();
        send_frame(8'h33, 8'h02, MY, 8'h03, SIM, 64'h0, 64'h0);
        n_chk++; if (err_cnt !== 8'(m_err) || sig_valid !== '0) begin
            n_fail++; $display("FAIL mid_leftover: got err %0d vld %b want %0d 0", err_cnt, sig_valid, m_err);
        end
    endtask

    task automatic test_eos;
        logic [63:0] eh;
        eh = hdr(8'hFF, MY, 8'h00, 8'h00, SIM);
        tx_ready = 1'b1;
        eos_req = 1'b1;
        tick();
        eos_req = 1'b0;
        n_chk++; if (tx_valid !== 1'b1 || tx_data !== eh || eos_done !== 1'b0) begin
            n_fail++; $display("FAIL eos_hdr: got v%b %h d%b want v1 %h d0", tx_valid, tx_data, eos_done, eh);
        end
        tick();
        n_chk++; if (eos_done !== 1'b1 || put_status !== 1'b0) begin
            n_fail++; $display("FAIL eos_done: got d%b s%b want d1 s0", eos_done, put_status);
        end
        put_req = 1'b1; put_logic = 1'b0;
        tick();
        put_req = 1'b0;
        n_chk++; if (put_status !== 1'b0 || tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL eos_block_put: got s%b v%b want s0 v0", put_status, tx_valid);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_put_bit();
        test_put_logic_stall();
        test_put_random();
        test_rx_get();
        test_rx_bad_sim();
        test_rx_random();
        test_get_collision();
        test_reset_midframe();
        test_eos();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shunt_fringe.md
# shunt_fringe

Hardware fringe bridge between a local partition and a remote partition.
- Keeps a per-signal receive database: payload, source ID and a data-valid flag.
- Serialises outbound puts and the end-of-simulation (EOS) notice into framed words on a TX stream.
- Parses inbound frames from an RX stream into the database.
- Provides a free-running cycle timestamp.
- Sits between a partition wrapper (initiator or target) and the inter-partition link.

## Interface
Parameters:
- N_SIG, 4, number of signal database entries; index width SW = clog2(N_SIG).
- DW, 64, payload word width.
- MY_ID, 8'h01, this partition's 8-bit ID.
- SIM_ID, 32'h0, simulation ID; inbound frames must match it.

Ports:
- clk_i  in  1  sole clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- put_req_i  in  1  put request; accepted only when idle.
- put_dst_i  in  8  destination partition ID.
- put_sig_i  in  SW  destination signal index.
- put_logic_i  in  1  0 = bit type (1 payload word); 1 = logic type (value word + X/Z-mask word).
- put_data_i / put_mask_i  in  DW  payload value / mask.
- put_status_o  out  1  busy: a put or EOS frame is in flight.
- get_req_i  in  1  get request (single cycle).
- get_src_i  in  8  expected source ID.
- get_sig_i  in  SW  signal index.
- get_success_o  out  1  one-cycle pulse, one cycle after a successful get.
- get_data_o / get_mask_o  out  DW  data returned by the last successful get; held until the next success.
- sig_valid_o  out  N_SIG  per-entry data_valid flags.
- eos_req_i  in  1  request to send EOS.
- eos_done_o  out  1  sticky; high once the EOS frame has been sent.
- time_o  out  32  cycle counter.
- tx_valid_o / tx_ready_i / tx_data_o  out/in/out  1/1/DW  outbound word stream.
- rx_valid_i / rx_ready_o / rx_data_i  in/out/in  1/1/DW  inbound word stream.
- err_cnt_o  out  8  count of dropped inbound frames; saturates at 8'hFF.

## Operation
Header word layout:
- [DW-1:DW-8] type: 8'h01 = BIT, 8'h02 = LOGIC, 8'hFF = EOS.
- [DW-9:DW-16] src ID; [DW-17:DW-24] dst ID; [DW-25:DW-32] signal index.
- [31:0] SIM_ID.
- Frame body: BIT header is followed by 1 payload word; LOGIC by 2 (value, then mask); EOS has none.

TX FSM (IDLE, HDR, PAY0, PAY1, EOS_HDR):
- IDLE, put_req_i, eos_done_o = 0: latch all put inputs; go to HDR; put_status_o = 1.
- IDLE, eos_req_i, no put_req_i: go to EOS_HDR; put_status_o = 1. If both requests are asserted together, the put wins and EOS stays pending until idle again.
- HDR sends src = MY_ID. Each word is held stable on tx_data_o with tx_valid_o = 1 until the cycle tx_ready_i = 1.
- HDR → PAY0. PAY0 → PAY1 if logic, else IDLE. PAY1 → IDLE.
- EOS_HDR → IDLE on acceptance; set eos_done_o.
- put_req_i while busy, or after EOS is done, is ignored. No queueing.

RX FSM (R_HDR, R_PAY0, R_PAY1, R_DROP):
- rx_ready_o = 1 in every state; one word is consumed per rx_valid_i cycle.
- A header is accepted if dst == MY_ID, SIM_ID matches, signal index < N_SIG and the type is BIT or LOGIC.
- Accepted frames: payload words go into db[sig]. Also store src ID; mask = 0 for BIT. data_valid[sig] is set on the final payload word.
- Rejected headers: increment err_cnt_o, then discard the frame's payload words in R_DROP. The payload count comes from the type; unknown types have 0 payload words.
- Inbound EOS matching MY_ID/SIM_ID sets eos_done_o.

Get (evaluated on pre-edge state):
- Success requires data_valid[get_sig_i] = 1 and stored src == get_src_i.
- On success: next cycle pulse get_success_o, load get_data_o/get_mask_o, clear data_valid.
- Otherwise get_success_o = 0 and nothing changes.
- If an RX final-word write hits the same entry in the same cycle: get returns the old data, and the new data and valid = 1 remain.

## Timing
- Reset values: all outputs 0, including time_o = 0, err_cnt_o = 0, tx_valid_o = 0, eos_done_o = 0. rx_ready_o = 0 during reset; 1 from the first cycle after reset.
- time_o increments every cycle and wraps 32'hFFFFFFFF → 0.
- Put latency: header appears on tx_data_o the cycle after acceptance.
- With tx_ready_i held high, a BIT put occupies 2 TX cycles and a LOGIC put 3. put_status_o falls the cycle after the last word is accepted.
- A new put can be accepted in the first IDLE cycle.
- RX write latency: data_valid is visible on sig_valid_o the cycle after the final payload word.
- An asynchronous reset mid-frame aborts both FSMs to IDLE/R_HDR and clears the database. The partial frame is lost, and the remaining link words are parsed as new headers.

## Test plan
- Reset release: time_o counts 0, 1, 2…; all valids 0; put_status_o = 0.
- Put BIT dst = 8'h02, sig = 1, data = 64'h1234, tx_ready_i = 1 → header {01,01,02,01,SIM_ID}, then 64'h1234. put_status_o is high for 2 cycles. A second put_req_i during busy is ignored.
- Put LOGIC with tx_ready_i low for 3 cycles → header held stable with tx_valid_o high. After that, value and mask follow in order.
- RX BIT frame src 02 → sig 0, data 64'hAB → sig_valid_o[0] = 1. get(src 02, sig 0) → get_success_o pulse, get_data_o = 64'hAB, valid cleared. A repeat get → no pulse.
- RX frame with wrong SIM_ID carrying 1 payload word → err_cnt_o = 1, no valid set. The next valid frame is parsed correctly.
- eos_req_i → EOS header sent, eos_done_o = 1. A subsequent put_req_i is ignored.
